// File: rtl/data_cache_controller_if.sv
// CPU-side request/response and block-memory signals of the data cache.
interface data_cache_controller_if;
  // Pipeline (MEM stage) side
  logic         READ;
  logic         WRITE;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [2:0]   FUNCT3;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  // Block memory side
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  // Environment view: drives requests and memory responses
  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, FUNCT3, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  // Cache controller view
  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, FUNCT3, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Misses refill (and evict dirty victims) through a 128-bit block port.
module data_cache_controller #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  data_cache_controller_if.slave  bus
);

  localparam int unsigned NUM_LINES = 2 ** INDEX_BITS;
  localparam int unsigned TAG_BITS  = 28 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

  state_e state_q, state_d;

  logic [127:0]          data_q [NUM_LINES];
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;

  // Block address of the miss being serviced; keeps the fill consistent
  // even if the pipeline drops its request mid-miss.
  logic [27:0]           miss_addr_q;
  logic [127:0]          fill_q;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  request;
  logic                  hit;
  logic                  store_hit;
  logic                  start_miss;
  logic [31:0]           sel_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           merged_word;
  logic [127:0]          merged_line;

  assign req_index  = bus.ADDRESS[3+INDEX_BITS:4];
  assign req_tag    = bus.ADDRESS[31:4+INDEX_BITS];
  assign miss_index = miss_addr_q[INDEX_BITS-1:0];
  assign miss_tag   = miss_addr_q[27:INDEX_BITS];
  assign request    = bus.READ | bus.WRITE;
  assign hit        = valid_q[req_index] & (tag_q[req_index] == req_tag);
  assign store_hit  = (state_q == StIdle) & bus.WRITE & hit;
  assign start_miss = (state_q == StIdle) & request & ~hit;

  // Word/byte/half selection from the addressed line
  always_comb begin
    sel_word = data_q[req_index][{bus.ADDRESS[3:2], 5'b0} +: 32];
    sel_byte = sel_word[{bus.ADDRESS[1:0], 3'b0} +: 8];
    sel_half = sel_word[{bus.ADDRESS[1], 4'b0} +: 16];
  end

  // Load data with sign/zero extension; zero unless a pure load hits
  always_comb begin
    bus.READDATA = '0;
    if (bus.READ && !bus.WRITE && hit) begin
      case (bus.FUNCT3)
        3'b000:  bus.READDATA = {{24{sel_byte[7]}}, sel_byte};
        3'b100:  bus.READDATA = {24'b0, sel_byte};
        3'b001:  bus.READDATA = {{16{sel_half[15]}}, sel_half};
        3'b101:  bus.READDATA = {16'b0, sel_half};
        default: bus.READDATA = sel_word;
      endcase
    end
  end

  // Store merge of byte/half/word into the addressed line
  always_comb begin
    merged_word = sel_word;
    case (bus.FUNCT3)
      3'b000:  merged_word[{bus.ADDRESS[1:0], 3'b0} +: 8] = bus.WRITEDATA[7:0];
      3'b001:  merged_word[{bus.ADDRESS[1], 4'b0} +: 16] = bus.WRITEDATA[15:0];
      default: merged_word = bus.WRITEDATA;
    endcase
    merged_line = data_q[req_index];
    merged_line[{bus.ADDRESS[3:2], 5'b0} +: 32] = merged_word;
  end

  // Miss FSM next state and memory/stall outputs
  always_comb begin
    state_d           = state_q;
    bus.BUSYWAIT      = 1'b0;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = '0;
    bus.MEM_WRITEDATA = '0;
    case (state_q)
      StIdle: begin
        if (request && !hit) begin
          bus.BUSYWAIT = 1'b1;
          if (valid_q[req_index] && dirty_q[req_index]) state_d = StWriteback;
          else                                          state_d = StFetch;
        end
      end
      StWriteback: begin
        bus.BUSYWAIT      = 1'b1;
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDRESS   = {tag_q[miss_index], miss_index};
        bus.MEM_WRITEDATA = data_q[miss_index];
        if (!bus.MEM_BUSYWAIT) state_d = StFetch;
      end
      StFetch: begin
        bus.BUSYWAIT    = 1'b1;
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = miss_addr_q;
        if (!bus.MEM_BUSYWAIT) state_d = StUpdate;
      end
      StUpdate: begin
        bus.BUSYWAIT = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register and per-line valid/dirty bits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (store_hit) dirty_q[req_index] <= 1'b1;
      if (state_q == StUpdate) begin
        valid_q[miss_index] <= 1'b1;
        dirty_q[miss_index] <= 1'b0;
      end
    end
  end

  // Data/tag arrays and miss bookkeeping (no reset needed)
  always_ff @(posedge CLK) begin
    if (start_miss) miss_addr_q <= bus.ADDRESS[31:4];
    if (state_q == StFetch && !bus.MEM_BUSYWAIT) fill_q <= bus.MEM_READDATA;
    if (!RESET) begin
      if (store_hit) data_q[req_index] <= merged_line;
      if (state_q == StUpdate) begin
        data_q[miss_index] <= fill_q;
        tag_q[miss_index]  <= miss_tag;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench: flat golden memory plus a line-residency model predict
// load data and stall counts; a latency-based block memory answers requests.
module tb_data_cache_controller;

  localparam int MEM_LAT = 3;
  localparam int NBLK    = 64;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  data_cache_controller_if bus ();

  data_cache_controller #(.INDEX_BITS(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] golden  [NBLK];
  logic [127:0] backing [NBLK];
  bit           res_valid [8];
  bit           res_dirty [8];
  logic [2:0]   res_tag   [8];

  // Block memory: answers MEM_LAT cycles after a request appears
  initial begin
    int cnt;
    cnt = 0;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        bus.MEM_BUSYWAIT = 1'b1;
        cnt = 0;
      end else begin
        if (!bus.MEM_BUSYWAIT) begin
          bus.MEM_BUSYWAIT = 1'b1;
          cnt = 0;
        end
        if (bus.MEM_READ || bus.MEM_WRITE) begin
          cnt++;
          if (cnt >= MEM_LAT) begin
            bus.MEM_BUSYWAIT = 1'b0;
            if (bus.MEM_WRITE) backing[bus.MEM_ADDRESS[5:0]] = bus.MEM_WRITEDATA;
            else bus.MEM_READDATA = backing[bus.MEM_ADDRESS[5:0]];
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_load(input logic [127:0] blk, input logic [31:0] addr,
                                           input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = blk[addr[3:2]*32 +: 32];
    b = w[addr[1:0]*8 +: 8];
    h = w[addr[1]*16 +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Architectural state after reset: dirty lines are lost
  task automatic reset_model();
    for (int i = 0; i < NBLK; i++) golden[i] = backing[i];
    for (int i = 0; i < 8; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
    end
  endtask

  // Predict stalls/data of one access and advance the model
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, output int exp_stalls,
                              output logic [31:0] exp_data, output bit exp_wb,
                              output logic [27:0] exp_wb_addr);
    int blk;
    int idx;
    logic [2:0] tag;
    blk = int'(addr[9:4]);
    idx = int'(addr[6:4]);
    tag = addr[9:7];
    exp_wb = 1'b0;
    exp_wb_addr = '0;
    exp_data = '0;
    if (res_valid[idx] && res_tag[idx] == tag) begin
      exp_stalls = 0;
    end else begin
      exp_wb = res_valid[idx] && res_dirty[idx];
      exp_wb_addr = {22'b0, res_tag[idx], addr[6:4]};
      exp_stalls = exp_wb ? 2 * MEM_LAT + 2 : MEM_LAT + 2;
      res_valid[idx] = 1'b1;
      res_dirty[idx] = 1'b0;
      res_tag[idx] = tag;
    end
    if (wr) begin
      case (f3)
        3'b000:  golden[blk][addr[3:0]*8 +: 8] = wdata[7:0];
        3'b001:  golden[blk][addr[3:1]*16 +: 16] = wdata[15:0];
        default: golden[blk][addr[3:2]*32 +: 32] = wdata;
      endcase
      res_dirty[idx] = 1'b1;
    end else begin
      exp_data = exp_load(golden[blk], addr, f3);
    end
  endtask

  // Drive one request until BUSYWAIT drops; called at posedge+1, returns at posedge+1
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, output int stalls,
                        output logic [31:0] rdata, output int rd_cyc, output logic [27:0] rd_addr,
                        output int wr_cyc, output logic [27:0] wr_addr,
                        output logic [127:0] wr_data, output bit timeout);
    bit done;
    done = 1'b0;
    stalls = 0;
    rdata = '0;
    rd_cyc = -1;
    wr_cyc = -1;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    bus.READ = rd;
    bus.WRITE = wr;
    bus.ADDRESS = addr;
    bus.WRITEDATA = wdata;
    bus.FUNCT3 = f3;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge CLK);
      if (bus.MEM_READ && rd_cyc < 0) begin
        rd_cyc = cyc;
        rd_addr = bus.MEM_ADDRESS;
      end
      if (bus.MEM_WRITE && wr_cyc < 0) begin
        wr_cyc = cyc;
        wr_addr = bus.MEM_ADDRESS;
        wr_data = bus.MEM_WRITEDATA;
      end
      if (!bus.BUSYWAIT) begin
        rdata = bus.READDATA;
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge CLK);
      #1;
    end
    timeout = !done;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  int           st, es, rc, wc;
  logic [31:0]  rd_v, ed;
  logic [27:0]  ra, wa, ewa;
  logic [127:0] wd;
  bit           to, ewb;

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    reset_model();
    @(negedge CLK);
    checks++; if (bus.BUSYWAIT !== 1'b0) begin errors++;
      $display("FAIL reset_busywait got %b want 0", bus.BUSYWAIT); end
    checks++; if (bus.MEM_READ !== 1'b0) begin errors++;
      $display("FAIL reset_mem_read got %b want 0", bus.MEM_READ); end
    checks++; if (bus.MEM_WRITE !== 1'b0) begin errors++;
      $display("FAIL reset_mem_write got %b want 0", bus.MEM_WRITE); end
    checks++; if (bus.MEM_ADDRESS !== 28'h0) begin errors++;
      $display("FAIL reset_mem_address got %h want 0", bus.MEM_ADDRESS); end
    checks++; if (bus.MEM_WRITEDATA !== 128'h0) begin errors++;
      $display("FAIL reset_mem_writedata got %h want 0", bus.MEM_WRITEDATA); end
    checks++; if (bus.READDATA !== 32'h0) begin errors++;
      $display("FAIL reset_readdata got %h want 0", bus.READDATA); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_cold_lw();
    model_access(1'b0, 32'h40, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != es) begin errors++;
      $display("FAIL cold_lw_stalls got %0d want %0d", st, es); end
    checks++; if (rc != 1 || ra !== 28'h4) begin errors++;
      $display("FAIL cold_lw_fetch got cyc %0d addr %h want cyc 1 addr 4", rc, ra); end
    checks++; if (rd_v !== 32'h000080FF || rd_v !== ed) begin errors++;
      $display("FAIL cold_lw_data got %h want %h", rd_v, 32'h000080FF); end
  endtask

  task automatic test_extension();
    logic [31:0] addrs [4];
    logic [2:0]  f3s   [4];
    logic [31:0] exps  [4];
    addrs = '{32'h40, 32'h41, 32'h40, 32'h40};
    f3s   = '{3'b000, 3'b100, 3'b001, 3'b101};
    exps  = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      model_access(1'b0, addrs[i], 32'h0, f3s[i], es, ed, ewb, ewa);
      access(1'b1, 1'b0, addrs[i], 32'h0, f3s[i], st, rd_v, rc, ra, wc, wa, wd, to);
      checks++; if (to || st != 0 || rd_v !== exps[i]) begin errors++;
        $display("FAIL extension_%0d got stalls %0d data %h want stalls 0 data %h",
                 i, st, rd_v, exps[i]); end
    end
  endtask

  task automatic test_store_hit();
    model_access(1'b1, 32'h42, 32'h123456AB, 3'b000, es, ed, ewb, ewa);
    access(1'b0, 1'b1, 32'h42, 32'h123456AB, 3'b000, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != 0) begin errors++;
      $display("FAIL sb_hit_stalls got %0d want 0", st); end
    model_access(1'b0, 32'h40, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != 0 || rd_v !== 32'h00AB80FF) begin errors++;
      $display("FAIL sb_hit_readback got %h stalls %0d want 00ab80ff stalls 0", rd_v, st); end
  endtask

  task automatic test_dirty_conflict();
    model_access(1'b0, 32'h140, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h140, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != 2 * MEM_LAT + 2 || st != es) begin errors++;
      $display("FAIL dirty_stalls got %0d want %0d", st, 2 * MEM_LAT + 2); end
    checks++; if (wc != 1 || wa !== 28'h4 || wd[31:0] !== 32'h00AB80FF) begin errors++;
      $display("FAIL dirty_writeback got cyc %0d addr %h data %h want cyc 1 addr 4 data 00ab80ff",
               wc, wa, wd[31:0]); end
    checks++; if (rc != MEM_LAT + 1 || ra !== 28'h14) begin errors++;
      $display("FAIL dirty_fetch got cyc %0d addr %h want cyc %0d addr 14", rc, ra, MEM_LAT + 1); end
    checks++; if (rd_v !== ed) begin errors++;
      $display("FAIL dirty_data got %h want %h", rd_v, ed); end
  endtask

  task automatic test_reset_mid_fetch();
    bus.READ = 1'b1;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 32'h80;
    bus.FUNCT3 = 3'b010;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++; if (bus.MEM_READ !== 1'b1) begin errors++;
      $display("FAIL rst_fetch_started got %b want 1", bus.MEM_READ); end
    @(posedge CLK);
    #1 RESET = 1'b1;
    bus.READ = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    reset_model();
    @(negedge CLK);
    checks++; if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b0) begin errors++;
      $display("FAIL rst_fetch_abandon got mem_read %b busywait %b want 0 0",
               bus.MEM_READ, bus.BUSYWAIT); end
    @(posedge CLK);
    #1;
    model_access(1'b0, 32'h80, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h80, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != es || rc != 1 || rd_v !== ed) begin errors++;
      $display("FAIL rst_refetch got stalls %0d cyc %0d data %h want stalls %0d cyc 1 data %h",
               st, rc, rd_v, es, ed); end
  endtask

  task automatic test_read_write_both();
    model_access(1'b0, 32'h44, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    model_access(1'b1, 32'h44, 32'hDEADBEEF, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b1, 32'h44, 32'hDEADBEEF, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != 0) begin errors++;
      $display("FAIL rw_both_stalls got %0d want 0", st); end
    model_access(1'b0, 32'h44, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || rd_v !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rw_both_readback got %h want deadbeef", rd_v); end
  endtask

  task automatic test_drop_mid_miss();
    bit done;
    done = 1'b0;
    model_access(1'b0, 32'h1C0, 32'h0, 3'b010, es, ed, ewb, ewa);
    bus.READ = 1'b1;
    bus.ADDRESS = 32'h1C0;
    bus.FUNCT3 = 3'b010;
    @(negedge CLK);
    checks++; if (bus.BUSYWAIT !== 1'b1) begin errors++;
      $display("FAIL drop_miss_stall got %b want 1", bus.BUSYWAIT); end
    @(posedge CLK);
    #1 bus.READ = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) done = 1'b1;
    end
    checks++; if (!done) begin errors++;
      $display("FAIL drop_miss_finish got busy want idle within 50 cycles"); end
    @(posedge CLK);
    #1;
    model_access(1'b0, 32'h1C0, 32'h0, 3'b010, es, ed, ewb, ewa);
    access(1'b1, 1'b0, 32'h1C0, 32'h0, 3'b010, st, rd_v, rc, ra, wc, wa, wd, to);
    checks++; if (to || st != 0 || rd_v !== ed) begin errors++;
      $display("FAIL drop_miss_resident got stalls %0d data %h want stalls 0 data %h",
               st, rd_v, ed); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    int          op;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 2));
      addr = {22'b0, 6'($urandom_range(0, NBLK - 1)), 4'($urandom_range(0, 15))};
      wdata = $urandom;
      f3 = 3'($urandom_range(0, 7));
      model_access(op != 0, addr, wdata, f3, es, ed, ewb, ewa);
      access(op != 1, op != 0, addr, wdata, f3, st, rd_v, rc, ra, wc, wa, wd, to);
      checks++; if (to || st != es) begin errors++;
        $display("FAIL random_%0d_stalls addr %h got %0d want %0d", n, addr, st, es); end
      if (op == 0) begin
        checks++; if (rd_v !== ed) begin errors++;
          $display("FAIL random_%0d_data addr %h f3 %0d got %h want %h", n, addr, f3, rd_v, ed);
        end
      end
      if (ewb) begin
        checks++; if (wa !== ewa) begin errors++;
          $display("FAIL random_%0d_wb_addr got %h want %h", n, wa, ewa); end
      end
    end
  endtask

  initial begin
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = '0;
    bus.WRITEDATA = '0;
    bus.FUNCT3 = '0;
    for (int i = 0; i < NBLK; i++) backing[i] = {$urandom, $urandom, $urandom, $urandom};
    backing[4][31:0] = 32'h000080FF;
    test_reset();
    test_cold_lw();
    test_extension();
    test_store_hit();
    test_dirty_conflict();
    test_reset_mid_fetch();
    test_read_write_both();
    test_drop_mid_miss();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
